// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game sequencer: FSM state encoding, the level
// ceiling and the shift-period helper used when speed-up is enabled.
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam logic [3:0] MAX_LEVEL = 4'd15;

  // Shift period for a level: base - lvl*step, floored at min_p. The product
  // is formed in 36 bits so a large step can never wrap into a long period.
  function automatic logic [31:0] calc_period(input logic [31:0] base,
                                              input logic [31:0] min_p,
                                              input logic [31:0] step,
                                              input logic [3:0]  lvl);
    logic [35:0] dec;
    logic [31:0] res;
    dec = {32'd0, lvl} * {4'd0, step};
    if (base <= min_p) begin
      res = min_p;
    end else if (dec >= {4'd0, (base - min_p)}) begin
      res = min_p;
    end else begin
      res = base - dec[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Link between the sequencer and the obstacle/score datapath.
//   master (sequencer): drives shift_enable, start_game, jump_trigger,
//                       force_game_over; reads game_over, score.
//   slave  (datapath) : the mirror image.
// -----------------------------------------------------------------------------
interface game_sequencer_if;
  logic        shift_enable;
  logic        start_game;
  logic        jump_trigger;
  logic        force_game_over;
  logic        game_over;
  logic [31:0] score;

  modport master (
    output shift_enable, start_game, jump_trigger, force_game_over,
    input  game_over, score
  );

  modport slave (
    input  shift_enable, start_game, jump_trigger, force_game_over,
    output game_over, score
  );
endinterface

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings an asynchronous push button into the clock domain and emits a
// one-cycle registered pulse on its rising edge. A level first sampled high
// at edge E0 produces rise_o high in the cycle after E2.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   btn_i  : raw button level
//   rise_o : one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchroniser chain, one-cycle-delayed copy and registered edge detect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Top-level game controller: conditions the start/jump buttons, runs the
// IDLE/RUN/PAUSE/OVER FSM, generates the shift tick and (optionally) raises
// the speed level as the score grows.
// Optional feature macro: GAME_SPEEDUP_EN (level/period scaling). Without it
// the period is fixed at BASE_PERIOD and level reads 0.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   btn_start  : raw start/pause button
//   btn_jump   : raw jump button
//   dp         : datapath link (pulses out, game_over/score in)
//   state      : IDLE=0, RUN=1, PAUSE=2, OVER=3
//   level      : current speed level 0..15
// -----------------------------------------------------------------------------
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 32'd25000000,
  parameter int unsigned MIN_PERIOD  = 32'd5000000,
  parameter int unsigned PERIOD_STEP = 32'd2500000,
  parameter int unsigned LEVEL_SCORE = 32'd100,
  parameter int unsigned OVER_HOLD   = 32'd50000000,
  parameter int unsigned PAUSE_LIMIT = 32'd500000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             btn_start,
  input  logic             btn_jump,
  game_sequencer_if.master dp,
  output logic [1:0]       state,
  output logic [3:0]       level
);

  logic start_rise_s;
  logic jump_rise_s;

  btn_sync_edge u_start_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .btn_i (btn_start),
    .rise_o(start_rise_s)
  );

  btn_sync_edge u_jump_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .btn_i (btn_jump),
    .rise_o(jump_rise_s)
  );

  game_state_e state_q;
  logic [31:0] div_q;
  logic [31:0] period_q;
  logic [31:0] hold_q;
  logic [31:0] pause_q;
  logic        shift_q;
  logic        start_q;
  logic        jump_q;
  logic        force_q;
  logic [31:0] next_period_s;
  logic        restart_s;

`ifdef GAME_SPEEDUP_EN
  logic [3:0]  level_q;
  logic [31:0] thr_q;

  // The period only changes at a divider wrap, using the level held then.
  assign next_period_s = calc_period(BASE_PERIOD, MIN_PERIOD, PERIOD_STEP, level_q);
  assign level         = level_q;
`else
  assign next_period_s = BASE_PERIOD;
  assign level         = 4'd0;

  // Score and scaling parameters have no consumer in this build.
  wire [31:0] unused_cfg = dp.score ^ MIN_PERIOD ^ PERIOD_STEP ^ LEVEL_SCORE
                           ^ {28'd0, MAX_LEVEL};
`endif

  // A start press begins a game from IDLE, or from OVER once the hold expired.
  assign restart_s = start_rise_s &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_OVER) && (hold_q == OVER_HOLD - 32'd1)));

  // Game FSM with divider, hold/pause counters and registered pulse outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      div_q    <= 32'd0;
      period_q <= BASE_PERIOD;
      hold_q   <= 32'd0;
      pause_q  <= 32'd0;
      shift_q  <= 1'b0;
      start_q  <= 1'b0;
      jump_q   <= 1'b0;
      force_q  <= 1'b0;
`ifdef GAME_SPEEDUP_EN
      level_q  <= 4'd0;
      thr_q    <= LEVEL_SCORE;
`endif
    end else begin
      shift_q <= 1'b0;
      start_q <= 1'b0;
      jump_q  <= 1'b0;
      force_q <= 1'b0;
      if (restart_s) begin
        start_q  <= 1'b1;
        state_q  <= ST_RUN;
        div_q    <= 32'd0;
        period_q <= BASE_PERIOD;
`ifdef GAME_SPEEDUP_EN
        level_q  <= 4'd0;
        thr_q    <= LEVEL_SCORE;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_RUN: begin
            if (jump_rise_s) begin
              jump_q <= 1'b1;
            end
`ifdef GAME_SPEEDUP_EN
            if ((dp.score >= thr_q) && (level_q < MAX_LEVEL)) begin
              level_q <= level_q + 4'd1;
              thr_q   <= thr_q + LEVEL_SCORE;
            end
`endif
            // game_over beats a pause request, which beats the divider wrap
            if (dp.game_over) begin
              state_q <= ST_OVER;
              hold_q  <= 32'd0;
            end else if (start_rise_s) begin
              state_q <= ST_PAUSE;
              pause_q <= 32'd0;
            end else if (div_q == period_q - 32'd1) begin
              shift_q  <= 1'b1;
              div_q    <= 32'd0;
              period_q <= next_period_s;
            end else begin
              div_q <= div_q + 32'd1;
            end
          end
          ST_PAUSE: begin
            // Divider is left untouched so a resume continues where it stopped.
            // Checking game_over first keeps force_game_over off while it is set.
            if (dp.game_over) begin
              state_q <= ST_OVER;
              hold_q  <= 32'd0;
            end else if (start_rise_s) begin
              state_q <= ST_RUN;
            end else if (pause_q == PAUSE_LIMIT - 32'd1) begin
              force_q <= 1'b1;
              state_q <= ST_OVER;
              hold_q  <= 32'd0;
            end else begin
              pause_q <= pause_q + 32'd1;
            end
          end
          ST_OVER: begin
            if (hold_q != OVER_HOLD - 32'd1) begin
              hold_q <= hold_q + 32'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign state              = state_q;
  assign dp.shift_enable    = shift_q;
  assign dp.start_game      = start_q;
  assign dp.jump_trigger    = jump_q;
  assign dp.force_game_over = force_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Directed bench for game_sequencer with small timing parameters. Expected
// pulses (kind + clock edge) are queued as stimulus is applied; a negedge
// monitor pops and compares every pulse the DUT emits.
// Pulse kinds: 0 shift_enable, 1 start_game, 2 jump_trigger, 3 force_game_over.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int unsigned BASE = 10;
  localparam int unsigned MINP = 4;
  localparam int unsigned STEP = 2;
  localparam int unsigned LSC  = 5;
  localparam int unsigned HOLD = 20;
  localparam int unsigned PLIM = 50;

`ifdef GAME_SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  ev_t exp_q[$];

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_jump  = 1'b0;
  logic [1:0] state;
  logic [3:0] level;
  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_fail = 0;

  game_sequencer_if dp_if ();

  game_sequencer #(
    .BASE_PERIOD(BASE),
    .MIN_PERIOD (MINP),
    .PERIOD_STEP(STEP),
    .LEVEL_SCORE(LSC),
    .OVER_HOLD  (HOLD),
    .PAUSE_LIMIT(PLIM)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .btn_start(btn_start),
    .btn_jump (btn_jump),
    .dp       (dp_if),
    .state    (state),
    .level    (level)
  );

  always #5 clk = ~clk;

  // Clock-edge counter: a pulse registered at edge k is seen with cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Expected shift period for a level, straight from the speed-up rule
  function automatic int pe(input int l);
    int v;
    if (!SPD) return int'(BASE);
    v = int'(BASE) - int'(STEP) * l;
    if (v < int'(MINP)) v = int'(MINP);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_ev(input int c, input int k);
    exp_q.push_back('{cyc: c, kind: k});
  endtask

  // Advance to 2 time units after the negedge that follows edge t
  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #2;
    end
  endtask

  // One-cycle press: sampled high at exactly the next edge (E0 = cyc+1)
  task automatic press_start();
    btn_start = 1'b1;
    @(negedge clk);
    #2;
    btn_start = 1'b0;
  endtask

  // Scoreboard: every pulse seen must match the head of the expected queue
  always @(negedge clk) begin : monitor
    logic [3:0] pulses;
    ev_t        e;
    pulses = {dp_if.force_game_over, dp_if.jump_trigger, dp_if.start_game, dp_if.shift_enable};
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (pulses[k] !== 1'b0) begin
          n_cmp++;
          if (exp_q.size() == 0) e = '{cyc: -1, kind: -1};
          else e = exp_q.pop_front();
          assert ((e.cyc == cyc) && (e.kind == k)) else begin
            n_fail++;
            $error("FAIL pulse: observed kind %0d at edge %0d expected kind %0d at edge %0d",
                   k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s, w, r, p, q, t, u;
    int l1, l3, l15;
    l1  = SPD ? 1 : 0;
    l3  = SPD ? 3 : 0;
    l15 = SPD ? 15 : 0;
    dp_if.game_over = 1'b0;
    dp_if.score     = 32'd0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_level", level, 0);
    check("rst_pulses", {dp_if.force_game_over, dp_if.jump_trigger,
                         dp_if.start_game, dp_if.shift_enable}, 0);
    goto(3);
    rst = 1'b0;

    // Jump held in IDLE: no pulse at all
    btn_jump = 1'b1;
    goto(cyc + 30);
    btn_jump = 1'b0;
    goto(cyc + 5);
    check("idle_state", state, 0);

    // Start: start_game at E0+3, then a shift every 10 cycles
    s = cyc + 4;
    expect_ev(s, 1);
    expect_ev(s + 10, 0);
    expect_ev(s + 20, 0);
    press_start();
    goto(s);
    check("run_state", state, 1);
    check("run_level", level, 0);
    goto(s + 20);
    check("pending_start", exp_q.size(), 0);

    // Speed-up to level 1: the wrap in progress keeps 10, the following uses level 1
    w = s + 20;
    dp_if.score = 32'd5;
    expect_ev(w + 10, 0);
    expect_ev(w + 10 + pe(l1), 0);
    goto(w + 1);
    check("level_1", level, l1);
    w = w + 10 + pe(l1);
    goto(w);
    check("pending_lvl1", exp_q.size(), 0);

    // score 15: level climbs one per cycle to 3
    dp_if.score = 32'd15;
    expect_ev(w + pe(l1), 0);
    expect_ev(w + pe(l1) + pe(l3), 0);
    goto(w + 2);
    check("level_3", level, l3);
    w = w + pe(l1) + pe(l3);
    goto(w);
    check("pending_lvl3", exp_q.size(), 0);

    // score 1000: level saturates at 15, period already on its floor
    dp_if.score = 32'd1000;
    expect_ev(w + pe(l3), 0);
    expect_ev(w + pe(l3) + pe(l15), 0);
    expect_ev(w + pe(l3) + 2 * pe(l15), 0);
    w = w + pe(l3) + 2 * pe(l15);
    goto(w);
    check("level_15", level, l15);
    check("pending_lvl15", exp_q.size(), 0);

    // game_over sampled on the wrap edge: no shift, OVER
    w = w + pe(l15);
    goto(w - 1);
    dp_if.game_over = 1'b1;
    goto(w);
    check("over_state", state, 3);
    goto(w + 5);
    press_start();
    goto(w + 10);
    check("over_ignore", state, 3);
    dp_if.game_over = 1'b0;
    dp_if.score     = 32'd0;

    // Start after the hold: restart with level 0 and period 10
    goto(w + 25);
    r = cyc + 4;
    expect_ev(r, 1);
    expect_ev(r + 10, 0);
    press_start();
    goto(r);
    check("restart_state", state, 1);
    check("restart_level", level, 0);
    goto(r + 10);
    check("pending_restart", exp_q.size(), 0);

    // Jump held 30 cycles in RUN: exactly one jump_trigger
    btn_jump = 1'b1;
    expect_ev(r + 14, 2);
    expect_ev(r + 20, 0);
    expect_ev(r + 30, 0);
    expect_ev(r + 40, 0);
    goto(r + 40);
    btn_jump = 1'b0;
    check("pending_jump", exp_q.size(), 0);

    // Pause three cycles into a period; jump while paused is dropped
    p = cyc + 4;
    press_start();
    goto(p);
    check("pause_state", state, 2);
    goto(p + 2);
    btn_jump = 1'b1;
    goto(p + 7);
    btn_jump = 1'b0;

    // Resume: divider continues from 3, so the next shift is 7 cycles later
    goto(p + 10);
    q = cyc + 4;
    expect_ev(q + 7, 0);
    expect_ev(q + 17, 0);
    press_start();
    goto(q);
    check("resume_state", state, 1);
    goto(q + 17);
    check("pending_resume", exp_q.size(), 0);

    // Pause timeout: force_game_over on the 50th paused cycle
    t = cyc + 4;
    expect_ev(t + 50, 3);
    press_start();
    goto(t);
    check("pause2_state", state, 2);
    goto(t + 49);
    check("pause_hold", state, 2);
    goto(t + 50);
    check("timeout_state", state, 3);
    check("pending_timeout", exp_q.size(), 0);

    // Restart, then apply RST between edges while a shift pulse is high
    goto(t + 70);
    u = cyc + 4;
    expect_ev(u, 1);
    expect_ev(u + 10, 0);
    press_start();
    goto(u);
    dp_if.score = 32'd1000;
    goto(u + 10);
    check("pre_reset_state", state, 1);
    check("pre_reset_level", level, SPD ? 10 : 0);
    check("pending_pre_reset", exp_q.size(), 0);
    #1 rst = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_level", level, 0);
    check("async_pulses", {dp_if.force_game_over, dp_if.jump_trigger,
                           dp_if.start_game, dp_if.shift_enable}, 0);
    goto(cyc + 3);
    rst = 1'b0;
    goto(cyc + 10);
    check("post_reset_state", state, 0);
    check("pending_final", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level controller that sequences the obstacle/score datapath (the block with shift_enable, jump_trigger, start_game, force_game_over inputs and game_over/score outputs).
- Conditions the raw start/jump buttons, runs the game FSM, generates the shift tick, and raises speed with score.
- Sits between the board I/O and the obstacle datapath.

Parameters:
- BASE_PERIOD, 25000000, clock cycles between shift ticks at level 0.
- MIN_PERIOD, 5000000, floor on the shift period.
- PERIOD_STEP, 2500000, period reduction per level.
- LEVEL_SCORE, 100, score increment per level-up.
- OVER_HOLD, 50000000, cycles after game over during which start is ignored.
- PAUSE_LIMIT, 500000000, maximum pause length before a forced game over.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- btn_start  in  1  raw start/pause button, asynchronous.
- btn_jump  in  1  raw jump button, asynchronous.
- game_over  in  1  game-over flag from the datapath.
- score  in  32  score from the datapath.
- shift_enable  out  1  one-cycle shift tick.
- start_game  out  1  one-cycle game start/clear pulse.
- jump_trigger  out  1  one-cycle jump request.
- force_game_over  out  1  one-cycle forced-end pulse.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- level  out  4  current speed level, 0..15.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All pulse outputs 0. level=0. Divider, hold and pause counters 0. Synchroniser flops 0. Applies immediately, including mid-game.
- Button conditioning: 2-flop synchroniser plus rising-edge detect. Input first sampled high at edge E0 gives an internal rise pulse in the cycle after E2. Holding the button produces exactly one rise.
- All outputs are registered. A pulse output is high for exactly one cycle.
- IDLE: start_rise → start_game pulse; go to RUN; divider=0; level=0; next threshold=LEVEL_SCORE; period=BASE_PERIOD.
- RUN, divider:
  - Counts 0..period-1.
  - At period-1: shift_enable pulses and divider returns to 0.
  - The period is recomputed only at wrap: max(MIN_PERIOD, BASE_PERIOD - level*PERIOD_STEP). The subtraction saturates at MIN_PERIOD and never underflows.
- RUN, level:
  - When score >= threshold and level<15: level+1, threshold += LEVEL_SCORE. At most one level per cycle.
  - Level saturates at 15.
- RUN, jump: jump_rise → jump_trigger pulse. jump_rise in any other state is dropped.
- RUN, game over: game_over=1 → OVER; hold counter cleared. No shift_enable is issued in that cycle or any later cycle.
- RUN, pause: start_rise (with game_over=0) → PAUSE; pause counter cleared.
- Priority within RUN: game_over > start_rise > divider wrap.
- PAUSE:
  - Divider frozen. No shift_enable, no jump_trigger.
  - start_rise → RUN; divider resumes from its held value.
  - When the pause counter reaches PAUSE_LIMIT-1: force_game_over pulse, go to OVER.
  - If game_over=1 arrives while in PAUSE, go to OVER without a force_game_over pulse.
- OVER:
  - Hold counter counts to OVER_HOLD-1, then saturates.
  - start_rise before saturation is ignored.
  - start_rise after saturation → start_game pulse, RUN, level=0, divider=0, period=BASE_PERIOD, threshold reset.
- force_game_over is never asserted while game_over=1.
- Counter widths: 32 bits, unsigned.

Optional Feature:
- Macro: GAME_SPEEDUP_EN.
- Defined: level/period scaling as described above.
- Undefined: period fixed at BASE_PERIOD, level output tied to 0, threshold logic removed.

Decomposition:
- Package game_pkg: state encodings (IDLE/RUN/PAUSE/OVER) and MAX_LEVEL=15.
- Sub-module btn_sync_edge (2-flop synchroniser + registered rising-edge pulse), instantiated for btn_start and btn_jump.

Test Plan:
- Bench parameters: BASE_PERIOD=10, MIN_PERIOD=4, PERIOD_STEP=2, LEVEL_SCORE=5, OVER_HOLD=20, PAUSE_LIMIT=50.
- Start: release reset, press btn_start for 1 cycle → start_game high one cycle after E2, state=1, shift_enable every 10 cycles.
- Speed-up: drive score=5 → level=1, next period 8. score=15 → level climbs to 3, period 4. score=1000 → level=15, period stays 4.
- Game over: game_over=1 on the divider-wrap cycle → no shift_enable, state=3. btn_start 5 cycles later ignored. btn_start 25 cycles later → start_game, level=0, period 10.
- Jump: hold btn_jump 30 cycles in RUN → exactly one jump_trigger. Same press in IDLE or PAUSE → none.
- Pause timeout: btn_start in RUN → state=2, no shifts. After 50 cycles → one force_game_over pulse, state=3. Resume before 50 cycles → divider continues from its held count.
- Reset: assert RST mid-RUN between clock edges → all outputs 0 and state=0 without waiting for a clock edge.
